// File: rtl/phys_free_list_pkg.sv
// Shared rename definitions: register-file sizing, the physical tag type and
// the reset contents of the free list, shared with the map-table consumers.
package phys_free_list_pkg;

    localparam int PHYS_COUNT      = 64;
    localparam int ARCH_COUNT      = 32;
    localparam int PHYS_ADDR_WIDTH = $clog2(PHYS_COUNT);

    typedef logic [PHYS_ADDR_WIDTH-1:0] phys_tag_t;

    // Tags ARCH_COUNT.. are free at reset; the tail of the buffer is unused.
    function automatic int reset_tag(input int k, input int phys, input int arch);
        return (k < phys - arch) ? arch + k : 0;
    endfunction

endpackage

// File: rtl/phys_free_list_free_port_compact.sv
// Packs the enabled free ports into a dense, port-ordered list of tags and
// reports how many there are.
module free_port_compact
    import phys_free_list_pkg::*;
#(
    parameter int FREE_PORTS = 4,
    parameter int TAG_W      = PHYS_ADDR_WIDTH
) (
    input  logic [FREE_PORTS-1:0]                    free_en,
    input  logic [FREE_PORTS-1:0][TAG_W-1:0]         free_tag,
    output logic [FREE_PORTS-1:0][TAG_W-1:0]         comp_tag,
    output logic [$clog2(FREE_PORTS+1)-1:0]          comp_cnt
);

    localparam int FW = $clog2(FREE_PORTS + 1);

    logic [FW-1:0] prefix [FREE_PORTS+1];

    always_comb begin
        prefix[0] = '0;
        for (int i = 0; i < FREE_PORTS; i++) begin
            prefix[i+1] = prefix[i] + FW'(free_en[i]);
        end
    end

    // Slot j takes the enabled port that has exactly j enabled ports below it.
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path
        // leaves it unassigned and a latch is never inferred.
        comp_tag = '0;
        for (int j = 0; j < FREE_PORTS; j++) begin
            for (int i = 0; i < FREE_PORTS; i++) begin
                if (free_en[i] && prefix[i] == FW'(j)) begin
                    comp_tag[j] = free_tag[i];
                end
            end
        end
    end

    assign comp_cnt = prefix[FREE_PORTS];

endmodule

// File: rtl/phys_free_list.sv
// Physical register free list: circular buffer of free tags, multi-tag
// all-or-nothing allocation at the head and compacted returns at the tail.
module phys_free_list #(
    parameter int PHYS_COUNT      = phys_free_list_pkg::PHYS_COUNT,
    parameter int ARCH_COUNT      = phys_free_list_pkg::ARCH_COUNT,
    parameter int ALLOC_PORTS     = 4,
    parameter int FREE_PORTS      = 4,
    parameter int PHYS_ADDR_WIDTH = $clog2(PHYS_COUNT)
) (
    input  logic                                        clk,
    input  logic                                        sync_rst_n,
    input  logic                                        clk_en,
    input  logic [$clog2(ALLOC_PORTS+1)-1:0]            alloc_cnt,
    output logic                                        alloc_ok,
    output logic [ALLOC_PORTS-1:0][PHYS_ADDR_WIDTH-1:0] alloc_tag,
    output logic [ALLOC_PORTS-1:0]                      alloc_tag_valid,
    input  logic [FREE_PORTS-1:0]                       free_en,
    input  logic [FREE_PORTS-1:0][PHYS_ADDR_WIDTH-1:0]  free_tag,
    output logic [$clog2(PHYS_COUNT+1)-1:0]             free_count,
    output logic                                        err_overflow
);

    localparam int AW = $clog2(ALLOC_PORTS + 1);
    localparam int FW = $clog2(FREE_PORTS + 1);
    localparam int CW = $clog2(PHYS_COUNT + 1);
    localparam int SW = CW + 1;
    localparam int PW = PHYS_ADDR_WIDTH;

    logic [PW-1:0]                  entry [PHYS_COUNT];
    logic [PW-1:0]                  head;
    logic [PW-1:0]                  tail;
    logic [FREE_PORTS-1:0][PW-1:0]  comp_tag;
    logic [FW-1:0]                  comp_cnt;
    logic [AW-1:0]                  pop_cnt;
    logic [SW-1:0]                  room;
    logic [SW-1:0]                  push_cnt;
    logic                           overflow;

    free_port_compact #(
        .FREE_PORTS (FREE_PORTS),
        .TAG_W      (PW)
    ) u_free_port_compact (
        .free_en  (free_en),
        .free_tag (free_tag),
        .comp_tag (comp_tag),
        .comp_cnt (comp_cnt)
    );

    // Allocation view comes straight from registered state; returns made this
    // cycle are not visible until the next one.
    assign alloc_ok = SW'(free_count) >= SW'(alloc_cnt);

    always_comb begin
        for (int i = 0; i < ALLOC_PORTS; i++) begin
            alloc_tag[i]       = entry[head + PW'(i)];
            alloc_tag_valid[i] = SW'(free_count) > SW'(i);
        end
    end

    // Returns may fill only the space left after this cycle's pop.
    always_comb begin
        pop_cnt  = (clk_en && alloc_ok) ? alloc_cnt : '0;
        room     = SW'(PHYS_COUNT) - SW'(free_count) + SW'(pop_cnt);
        overflow = SW'(comp_cnt) > room;
        push_cnt = overflow ? room : SW'(comp_cnt);
    end

    // NOTE: the tag storage is reset along with the pointers because the
    // initial free tags live in it; it is a flop array, not a RAM macro.
    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            head         <= '0;
            tail         <= PW'(PHYS_COUNT - ARCH_COUNT);
            free_count   <= CW'(PHYS_COUNT - ARCH_COUNT);
            err_overflow <= 1'b0;
            for (int k = 0; k < PHYS_COUNT; k++) begin
                entry[k] <= PW'(phys_free_list_pkg::reset_tag(k, PHYS_COUNT, ARCH_COUNT));
            end
        end else if (clk_en) begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge state regardless of statement order.
            for (int k = 0; k < FREE_PORTS; k++) begin
                if (SW'(k) < push_cnt) begin
                    entry[tail + PW'(k)] <= comp_tag[k];
                end
            end
            head       <= head + PW'(pop_cnt);
            tail       <= tail + PW'(push_cnt);
            free_count <= CW'(SW'(free_count) - SW'(pop_cnt) + push_cnt);
            if (overflow) begin
                err_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/phys_free_list.md
PHYS_FREE_LIST -- requirements
Module: phys_free_list

Interface
REQ-001 Parameter PHYS_COUNT, default 64, number of physical registers; SHALL be a power of two.
REQ-002 Parameter ARCH_COUNT, default 32, number of architectural registers; physical tags 0..ARCH_COUNT-1 are mapped at reset.
REQ-003 Parameter ALLOC_PORTS, default 4, maximum tags handed out per cycle.
REQ-004 Parameter FREE_PORTS, default 4, maximum tags returned per cycle.
REQ-005 Parameter PHYS_ADDR_WIDTH, default $clog2(PHYS_COUNT), tag width.
REQ-006 clk  in  1  clock; all state updates on its rising edge.
REQ-007 sync_rst_n  in  1  reset, asynchronous, active-low.
REQ-008 clk_en  in  1  when low, no state changes (alloc and free both ignored).
REQ-009 alloc_cnt  in  $clog2(ALLOC_PORTS+1)  tags requested this cycle (0..ALLOC_PORTS).
REQ-010 alloc_ok  out  1  high when free_count >= alloc_cnt.
REQ-011 alloc_tag  out  PHYS_ADDR_WIDTH x ALLOC_PORTS  next ALLOC_PORTS tags at head, port 0 oldest.
REQ-012 alloc_tag_valid  out  ALLOC_PORTS  bit i high when free_count > i.
REQ-013 free_en  in  FREE_PORTS  per-port tag return strobe, any bit pattern legal.
REQ-014 free_tag  in  PHYS_ADDR_WIDTH x FREE_PORTS  tag returned on port i.
REQ-015 free_count  out  $clog2(PHYS_COUNT+1)  registered count of free tags.
REQ-016 err_overflow  out  1  sticky; set when a return would exceed PHYS_COUNT entries.

Function
REQ-017 Storage: circular buffer of PHYS_COUNT tag entries with registered head, tail pointers (PHYS_ADDR_WIDTH, natural wrap) and free_count.
REQ-018 alloc_tag[i] = entry[head+i] combinationally from registered state; zero extra latency.
REQ-019 Pop: when clk_en && alloc_ok && alloc_cnt>0, head += alloc_cnt at the edge; consumer uses alloc_tag[0..alloc_cnt-1] in that same cycle.
REQ-020 Stall: when alloc_ok low, no tags popped (all-or-nothing, never partial); consumer holds alloc_cnt.
REQ-021 Push: enabled free ports compacted in ascending port order; k-th enabled tag written to entry[tail+k]; tail += popcount(free_en).
REQ-022 Freed tags become allocatable the cycle after return; no same-cycle bypass to alloc_tag.
REQ-023 Simultaneous alloc and free: free_count_next = free_count - popped + pushed, both in the same edge; alloc_ok evaluated on pre-push count.
REQ-024 Free accepted regardless of alloc_ok or alloc_cnt.
REQ-025 Overflow: if free_count - popped + pushed > PHYS_COUNT, only the first (PHYS_COUNT - free_count + popped) enabled tags, in port order, are written; excess dropped; err_overflow set.
REQ-026 Wrap-around: pointer arithmetic modulo PHYS_COUNT; a multi-tag pop/push straddling entry PHYS_COUNT-1 -> 0 is contiguous.
REQ-027 Empty: free_count = 0 -> alloc_tag_valid = 0, alloc_ok = (alloc_cnt == 0).
REQ-028 No duplicate-tag or range checking on free_tag; caller's responsibility.

Reset
REQ-029 On sync_rst_n low, asynchronously: entry[k] = ARCH_COUNT+k for k < PHYS_COUNT-ARCH_COUNT, remaining entries 0; head = 0; tail = PHYS_COUNT-ARCH_COUNT (mod PHYS_COUNT); free_count = PHYS_COUNT-ARCH_COUNT; err_overflow = 0.
REQ-030 Reset mid-operation discards in-flight pops and pushes of that cycle; first post-reset alloc returns tag ARCH_COUNT.
REQ-031 After reset release, outputs reflect reset state: alloc_ok = (alloc_cnt <= PHYS_COUNT-ARCH_COUNT), alloc_tag[i] = ARCH_COUNT+i.

Structure
REQ-032 Shared rename package holds PHYS_COUNT, ARCH_COUNT and phys_tag_t; shared with gen_map_table consumers.
REQ-033 One sub-module, free_port_compact: combinational free_en/free_tag compaction producing ordered tags and popcount.
REQ-034 Block sits upstream of the map table: alloc_tag feeds the map-table physical-address write ports.

Verification
REQ-035 Reset, alloc_cnt=4 one cycle -> tags 32,33,34,35; free_count 32->28.
REQ-036 Drain: alloc_cnt=4 for 8 cycles -> free_count 0; next alloc_cnt=1 -> alloc_ok=0, head unchanged, alloc_tag_valid=0.
REQ-037 At free_count=0, free_en=0101 with tags 7,9 -> next cycle free_count=2, alloc_tag[0]=7, alloc_tag[1]=9.
REQ-038 free_count=2, alloc_cnt=2 plus free_en=1111 same cycle -> both popped, 4 pushed, free_count=4.
REQ-039 Wrap: head=62, free_count=4, alloc_cnt=4 -> tags from entries 62,63,0,1; head=2.
REQ-040 free_count=63, free_en=0011 -> one tag written, free_count=64, err_overflow=1 and held until reset.
